// File: rtl/and_gate_bist_ctrl_pkg.sv
// Shared state encodings and vector-class constants for the AND-lane BIST.
package and_gate_bist_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Vectors 0..3 are the exhaustive a/b pairs broadcast to all lanes.
  localparam int unsigned BASIC_VECS = 4;
  // Walking vectors start right after the basic set.
  localparam int unsigned WALK_BASE  = BASIC_VECS;
  // Bit positions of a and b within a basic vector index.
  localparam int unsigned VEC_A_BIT  = 1;
  localparam int unsigned VEC_B_BIT  = 0;

endpackage

// File: rtl/and1.sv
// Single two-input AND cell; one lane of the array under test.
module and1 (
  input  logic a,
  input  logic b,
  output logic out
);

  assign out = a & b;

endmodule

// File: rtl/and_bist_vec_gen.sv
// Maps a vector index to the per-lane a/b stimulus and the expected AND result.
module and_bist_vec_gen
  import and_gate_bist_ctrl_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned VEC_W = 3
) (
  input  logic [VEC_W-1:0] vec,
  output logic [LANES-1:0] a_c,
  output logic [LANES-1:0] b_c,
  output logic [LANES-1:0] expected_c
);

  // Basic vectors broadcast one a/b pair; walking vectors enable b on one lane only.
  always_comb begin
    a_c = '0;
    b_c = '0;
    if (vec < VEC_W'(WALK_BASE)) begin
      a_c = {LANES{vec[VEC_A_BIT]}};
      b_c = {LANES{vec[VEC_B_BIT]}};
    end else begin
      a_c = '1;
      b_c = LANES'(1) << (vec - VEC_W'(WALK_BASE));
    end
  end

  assign expected_c = a_c & b_c;

endmodule

// File: rtl/and_gate_bist_ctrl.sv
// BIST sequencer: applies the vector set to all AND lanes, checks results,
// and reports pass, a saturating error count and the first failing lane/vector.
module and_gate_bist_ctrl
  import and_gate_bist_ctrl_pkg::*;
#(
  parameter  int unsigned LANES   = 4,
  parameter  int unsigned SETTLE  = 1,
  parameter  int unsigned ERR_W   = 8,
  localparam int unsigned NUM_VEC = BASIC_VECS + LANES,
  localparam int unsigned VEC_W   = $clog2(NUM_VEC),
  localparam int unsigned LANE_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [LANE_W-1:0] fail_lane,
  output logic [VEC_W-1:0]  fail_vec,
  output logic [LANES-1:0]  dut_a,
  output logic [LANES-1:0]  dut_b,
  input  logic [LANES-1:0]  dut_out
);

  localparam int unsigned POP_W = $clog2(LANES + 1);
  localparam int unsigned SUM_W = ERR_W + POP_W;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

  state_t             state;
  logic [VEC_W-1:0]   vec;
  logic [SET_W-1:0]   settle_cnt;
  logic [LANES-1:0]   vec_a;
  logic [LANES-1:0]   vec_b;
  logic [LANES-1:0]   vec_expected;
  logic [LANES-1:0]   mism;
  logic [POP_W-1:0]   mism_pop;
  logic [LANE_W-1:0]  low_lane;
  logic [SUM_W-1:0]   err_sum;
  logic [ERR_W-1:0]   err_next;

  and_bist_vec_gen #(
    .LANES (LANES),
    .VEC_W (VEC_W)
  ) u_vec_gen (
    .vec        (vec),
    .a_c        (vec_a),
    .b_c        (vec_b),
    .expected_c (vec_expected)
  );

  assign mism = dut_out ^ vec_expected;

  // Mismatch popcount and lowest mismatching lane for the current sample
  always_comb begin
    mism_pop = '0;
    low_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      mism_pop = mism_pop + POP_W'(mism[i]);
      if (mism[i]) low_lane = LANE_W'(i);
    end
  end

  // Saturating accumulation of the error count
  always_comb begin
    err_sum  = SUM_W'(err_cnt) + SUM_W'(mism_pop);
    err_next = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : ERR_W'(err_sum);
  end

  // Sequencer FSM with registered outputs; err_cnt==0 marks "no failure captured yet"
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_lane  <= '0;
      fail_vec   <= '0;
      dut_a      <= '0;
      dut_b      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          dut_a <= '0;
          dut_b <= '0;
          if (start) begin
            err_cnt   <= '0;
            fail_lane <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
            vec       <= '0;
            busy      <= 1'b1;
            state     <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          dut_a      <= vec_a;
          dut_b      <= vec_b;
          settle_cnt <= SETTLE_LOAD;
          state      <= (SETTLE == 0) ? ST_CHECK : ST_WAIT;
        end
        ST_WAIT: begin
          if (settle_cnt == '0) state <= ST_CHECK;
          else                  settle_cnt <= settle_cnt - SET_W'(1);
        end
        ST_CHECK: begin
          err_cnt <= err_next;
          if ((mism != '0) && (err_cnt == '0)) begin
            fail_lane <= low_lane;
            fail_vec  <= vec;
          end
          if (vec == LAST_VEC) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_next == '0);
            dut_a <= '0;
            dut_b <= '0;
            state <= ST_DONE;
          end else begin
            vec   <= vec + VEC_W'(1);
            state <= ST_APPLY;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_gate_bist_ctrl.sv
// Self-checking bench for and_gate_bist_ctrl with fault-injected AND lane arrays.
module tb_and_gate_bist_ctrl;

  logic       clk;
  logic       rst;
  logic       start;

  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [1:0] fail_lane;
  logic [2:0] fail_vec;
  logic [3:0] dut_a, dut_b, dut_out, lane_raw;

  logic       busy_s, done_s, pass_s;
  logic [1:0] err_cnt_s;
  logic [1:0] fail_lane_s;
  logic [2:0] fail_vec_s;
  logic [3:0] dut_a_s, dut_b_s, dut_out_s, lane_raw_s;

  int         fault_mode;
  logic [1:0] fault_lane;

  int errors = 0;
  int checks = 0;

  and_gate_bist_ctrl #(.LANES(4), .SETTLE(1), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_lane(fail_lane), .fail_vec(fail_vec),
    .dut_a(dut_a), .dut_b(dut_b), .dut_out(dut_out)
  );

  and_gate_bist_ctrl #(.LANES(4), .SETTLE(1), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_cnt(err_cnt_s), .fail_lane(fail_lane_s), .fail_vec(fail_vec_s),
    .dut_a(dut_a_s), .dut_b(dut_b_s), .dut_out(dut_out_s)
  );

  for (genvar g = 0; g < 4; g++) begin : g_lanes
    and1 u_lane   (.a(dut_a[g]),   .b(dut_b[g]),   .out(lane_raw[g]));
    and1 u_lane_s (.a(dut_a_s[g]), .b(dut_b_s[g]), .out(lane_raw_s[g]));
  end

  // Fault injection on the main array: 1 stuck-at-1, 2 stuck-at-0, 3 all inverted
  always_comb begin
    dut_out = lane_raw;
    case (fault_mode)
      1: dut_out[fault_lane] = 1'b1;
      2: dut_out[fault_lane] = 1'b0;
      3: dut_out = ~lane_raw;
      default: ;
    endcase
  end

  // Saturation array always has every lane inverted
  assign dut_out_s = ~lane_raw_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         fault_mode;
    logic [1:0] fault_lane;
    int         extra_start;
    logic       exp_pass;
    logic [7:0] exp_err;
    logic [1:0] exp_lane;
    logic [2:0] exp_vec;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full run: start high in cycle 0, observe cycles 1..30
  task automatic run_vector(input int idx, input vec_t v);
    int busy_bad;
    int done_cnt;
    int done_at;
    int sat_done_at;
    busy_bad    = 0;
    done_cnt    = 0;
    done_at     = -1;
    sat_done_at = -1;
    @(negedge clk);
    fault_mode = v.fault_mode;
    fault_lane = v.fault_lane;
    start      = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
      if (v.extra_start > 0 && c == v.extra_start) start = 1'b1;
      if (v.extra_start > 0 && c == v.extra_start + 1) start = 1'b0;
      if (busy !== ((c >= 1) && (c <= 24))) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (done_s === 1'b1) sat_done_at = c;
      if (c == 25) begin
        check($sformatf("run%0d_pass", idx), 32'(pass), 32'(v.exp_pass));
        check($sformatf("run%0d_err_cnt", idx), 32'(err_cnt), 32'(v.exp_err));
        check($sformatf("run%0d_fail_lane", idx), 32'(fail_lane), 32'(v.exp_lane));
        check($sformatf("run%0d_fail_vec", idx), 32'(fail_vec), 32'(v.exp_vec));
        check($sformatf("run%0d_dut_ab_idle", idx), 32'({dut_a, dut_b}), 32'd0);
        check($sformatf("run%0d_sat_err_cnt", idx), 32'(err_cnt_s), 32'd3);
        check($sformatf("run%0d_sat_fail", idx), 32'({pass_s, fail_lane_s, fail_vec_s}), 32'd0);
      end
    end
    check($sformatf("run%0d_busy_window_bad", idx), 32'(busy_bad), 32'd0);
    check($sformatf("run%0d_done_count", idx), 32'(done_cnt), 32'd1);
    check($sformatf("run%0d_done_cycle", idx), 32'(done_at), 32'd25);
    check($sformatf("run%0d_sat_done_cycle", idx), 32'(sat_done_at), 32'd25);
    check($sformatf("run%0d_pass_held", idx), 32'(pass), 32'(v.exp_pass));
    check($sformatf("run%0d_err_held", idx), 32'(err_cnt), 32'(v.exp_err));
  endtask

  vec_t vt [7];

  initial begin
    int done_seen;

    vt[0] = '{0, 2'd0, 0,  1'b1, 8'd0,  2'd0, 3'd0};
    vt[1] = '{1, 2'd2, 0,  1'b0, 8'd6,  2'd2, 3'd0};
    vt[2] = '{2, 2'd0, 0,  1'b0, 8'd2,  2'd0, 3'd3};
    vt[3] = '{0, 2'd0, 10, 1'b1, 8'd0,  2'd0, 3'd0};
    vt[4] = '{1, 2'd1, 0,  1'b0, 8'd6,  2'd1, 3'd0};
    vt[5] = '{3, 2'd0, 0,  1'b0, 8'd32, 2'd0, 3'd0};
    vt[6] = '{2, 2'd3, 0,  1'b0, 8'd2,  2'd3, 3'd3};

    rst        = 1'b1;
    start      = 1'b0;
    fault_mode = 0;
    fault_lane = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pass", 32'(pass), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
    check("reset_fail_lane", 32'(fail_lane), 32'd0);
    check("reset_fail_vec", 32'(fail_vec), 32'd0);
    check("reset_dut_a", 32'(dut_a), 32'd0);
    check("reset_dut_b", 32'(dut_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vector(i, vt[i]);

    // Reset mid-run: lane 2 stuck-at-1 run aborted in cycle 12
    done_seen = 0;
    @(negedge clk);
    fault_mode = 1;
    fault_lane = 2'd2;
    start      = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
      if (c >= 13 && done === 1'b1) done_seen++;
      if (c == 12) begin
        check("abort_err_before_rst", 32'(err_cnt), 32'd3);
        check("abort_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
      end
      if (c == 13) begin
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dut_a", 32'(dut_a), 32'd0);
        check("abort_dut_b", 32'(dut_b), 32'd0);
        check("abort_err_cnt", 32'(err_cnt), 32'd0);
        check("abort_fail_lane", 32'(fail_lane), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        rst = 1'b0;
      end
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    // Fresh fault-free run after the abort
    run_vector(7, vt[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
